// File: rtl/matrix_bus_pkg.sv
// matrix_bus_pkg: shared definitions for the matrix-memory bus arbiter.
//   arb_state_t     - arbiter FSM states (IDLE/SETUP/ACTIVE/CLEAN)
//   MEM_READ/WRITE  - mem_RW encodings
//   ARB_ADDR_W      - default matrix-memory address width
package matrix_bus_pkg;

  localparam int unsigned ARB_ADDR_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_SETUP  = 2'b01,
    ARB_ACTIVE = 2'b10,
    ARB_CLEAN  = 2'b11
  } arb_state_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/matrix_bus_arbiter_pick.sv
// arb_pick: combinational 2-way winner selector.
//   req    [1:0] - request vector
//   rr_ptr       - requester favoured when both request (round-robin mode)
//   win    [1:0] - one-hot winner, zero when nobody requests
// Build option ARB_FIXED_PRIORITY_EN: requester 0 always wins a tie and
// rr_ptr is ignored.
module arb_pick
  import matrix_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
`ifdef ARB_FIXED_PRIORITY_EN
      2'b11:   win = 2'b01;
`else
      2'b11:   win = rr_ptr ? 2'b10 : 2'b01;
`endif
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/matrix_bus_arbiter.sv
// matrix_bus_arbiter: shares the single matrix-memory port between the
// execution engine (requester 0) and the host loader (requester 1). Every
// granted access runs SETUP -> ACTIVE (ACTIVE_CYCLES) -> CLEAN, then IDLE.
//
// Ports:
//   clk                 - rising-edge clock
//   reset               - asynchronous active-low reset
//   req       [1:0]     - per-requester request, held until its done pulse
//   req_addr0/req_addr1 - per-requester address
//   req_rw    [1:0]     - per-requester direction (1 = read, 0 = write)
//   gnt       [1:0]     - one-hot grant, SETUP through CLEAN
//   done      [1:0]     - one-cycle pulse in CLEAN for the granted requester
//   busy                - state is not IDLE
//   mem_address, mem_RW, nMem_Enable - memory-side port (enable active low)
//
// Build option ARB_FIXED_PRIORITY_EN: requester 0 wins every tie and rr_ptr
// is tied low.
module matrix_bus_arbiter
  import matrix_bus_pkg::*;
#(
  parameter int unsigned ADDR_W        = ARB_ADDR_W,
  parameter int unsigned ACTIVE_CYCLES = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [1:0]        req_rw,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_RW,
  output logic              nMem_Enable
);

  localparam logic [3:0] CNT_LOAD = 4'(ACTIVE_CYCLES - 1);

  arb_state_t  state;
  logic [3:0]  cnt;
  logic        rr_ptr;
  logic [1:0]  win;

`ifdef ARB_FIXED_PRIORITY_EN
  assign rr_ptr = 1'b0;
`endif

  arb_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .win    (win)
  );

  // The address/rw captured in IDLE go straight into the registered memory
  // outputs, which then double as the latch and stay stable through ACTIVE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      gnt         <= '0;
      done        <= '0;
      busy        <= 1'b0;
      mem_address <= '0;
      mem_RW      <= MEM_READ;
      nMem_Enable <= 1'b1;
      cnt         <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            gnt         <= win;
            busy        <= 1'b1;
            mem_address <= win[1] ? req_addr1 : req_addr0;
            mem_RW      <= win[1] ? req_rw[1] : req_rw[0];
            nMem_Enable <= 1'b1;
            state       <= ARB_SETUP;
          end
        end
        ARB_SETUP: begin
          nMem_Enable <= 1'b0;
          cnt         <= CNT_LOAD;
          state       <= ARB_ACTIVE;
        end
        ARB_ACTIVE: begin
          if (cnt == '0) begin
            nMem_Enable <= 1'b1;
            mem_address <= '0;
            mem_RW      <= MEM_READ;
            done        <= gnt;
`ifndef ARB_FIXED_PRIORITY_EN
            // Point away from the requester just served.
            rr_ptr      <= gnt[0];
`endif
            state       <= ARB_CLEAN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ARB_CLEAN: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_bus_arbiter.sv
module tb_matrix_bus_arbiter;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned AC     = 3;
  localparam int unsigned OW     = 7 + ADDR_W;

  logic              clk;
  logic              reset;
  logic [1:0]        req;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        req_rw;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_RW;
  logic              nMem_Enable;

  matrix_bus_arbiter #(.ADDR_W(ADDR_W), .ACTIVE_CYCLES(AC)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_addr0   (req_addr0),
    .req_addr1   (req_addr1),
    .req_rw      (req_rw),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .mem_address (mem_address),
    .mem_RW      (mem_RW),
    .nMem_Enable (nMem_Enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic              rw;
    int unsigned       cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] mk(input logic [1:0] g, input logic [1:0] d, input logic b,
                                       input logic n, input logic [ADDR_W-1:0] a, input logic r);
    return {g, d, b, n, a, r};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {gnt, done, busy, nMem_Enable, mem_address, mem_RW};
  endfunction

  localparam logic [OW-1:0] IDLE_V = {2'b00, 2'b00, 1'b0, 1'b1, {ADDR_W{1'b0}}, 1'b1};

  // Reference model: the port can accept a new request once every 3+AC cycles
  // after a grant; ties go to the requester not served last.
  initial begin : model
    int unsigned free_at;
    logic        rr;
    logic        w;
    exp_t        e;
    free_at = 0;
    rr      = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) begin
        exp_q.delete();
        free_at = 0;
        rr      = 1'b0;
      end else if (cyc >= free_at && req != 2'b00) begin
        if (req == 2'b01)      w = 1'b0;
        else if (req == 2'b10) w = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
        else                   w = 1'b0;
`else
        else                   w = rr;
`endif
        e.w   = w;
        e.a   = w ? req_addr1 : req_addr0;
        e.rw  = req_rw[w];
        e.cyc = cyc;
        exp_q.push_back(e);
        rr      = ~w;
        free_at = cyc + 3 + AC;
      end
    end
  end

  // Monitor: every cycle the bus outputs must match either the idle vector or
  // the expected phase of the transaction at the head of the queue.
  initial begin : monitor
    bit          in_txn;
    int unsigned k;
    exp_t        cur;
    logic [1:0]  oh;
    in_txn = 1'b0;
    k      = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_txn = 1'b0;
        check("reset_state", 32'(obs()), 32'(IDLE_V));
      end else begin
        if (!in_txn) begin
          if (gnt != 2'b00) begin
            if (exp_q.size() == 0) begin
              check("unexpected_grant", 32'(gnt), 32'd0);
            end else begin
              cur    = exp_q.pop_front();
              in_txn = 1'b1;
              k      = 0;
              check("grant_cycle", cyc, cur.cyc);
            end
          end else begin
            check("idle_outputs", 32'(obs()), 32'(IDLE_V));
          end
        end
        if (in_txn) begin
          oh = 2'(2'b01 << cur.w);
          if (k == 0)
            check("setup_phase", 32'(obs()), 32'(mk(oh, 2'b00, 1'b1, 1'b1, cur.a, cur.rw)));
          else if (k <= AC)
            check("active_phase", 32'(obs()), 32'(mk(oh, 2'b00, 1'b1, 1'b0, cur.a, cur.rw)));
          else if (k == AC + 1)
            check("clean_phase", 32'(obs()), 32'(mk(oh, oh, 1'b1, 1'b1, '0, 1'b1)));
          else begin
            check("return_idle", 32'(obs()), 32'(IDLE_V));
            in_txn = 1'b0;
          end
          k++;
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int idx);
    for (int i = 0; i < 40; i++) begin
      if (done[idx]) break;
      @(negedge clk);
    end
    check("done_seen", 32'(done[idx]), 32'd1);
  endtask

  task automatic wait_low();
    for (int i = 0; i < 40; i++) begin
      if (!nMem_Enable) break;
      @(negedge clk);
    end
    check("enable_low_seen", 32'(nMem_Enable), 32'd0);
  endtask

  initial begin : stim
    reset     = 1'b0;
    req       = 2'b00;
    req_addr0 = '0;
    req_addr1 = '0;
    req_rw    = 2'b11;
    tick(3);
    reset = 1'b1;
    tick(2);

    // Single read by requester 0.
    req = 2'b01; req_addr0 = 3'd5; req_rw = 2'b11;
    wait_done(0);
    req = 2'b00;
    tick(3);

    // Both requesting continuously: grants alternate.
    req = 2'b11; req_addr0 = 3'd2; req_addr1 = 3'd6; req_rw = 2'b11;
    tick(4 * (3 + AC) + 1);
    req = 2'b00;
    tick(AC + 4);

    // Requester 1 write.
    req = 2'b10; req_addr1 = 3'd7; req_rw = 2'b00;
    wait_done(1);
    req = 2'b00;
    tick(3);

    // Request withdrawn during ACTIVE.
    req = 2'b01; req_addr0 = 3'd1; req_rw = 2'b11;
    wait_low();
    req = 2'b00;
    wait_done(0);
    tick(AC + 5);

    // Asynchronous reset during ACTIVE.
    req = 2'b01; req_addr0 = 3'd4; req_rw = 2'b00;
    wait_low();
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset", 32'(obs()), 32'(IDLE_V));
    req = 2'b00;
    tick(2);
    reset = 1'b1;
    tick(2);
    req = 2'b01; req_addr0 = 3'd3; req_rw = 2'b11;
    wait_done(0);
    req = 2'b00;
    tick(3);

    // Randomized traffic; addresses and directions churn every cycle.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if (done[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
      req_addr0 = ADDR_W'($urandom);
      req_addr1 = ADDR_W'($urandom);
      req_rw    = 2'($urandom);
      tick(1);
    end

    req = 2'b00;
    tick(AC + 8);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
